// File: rtl/dmem_ctrl.sv
// dmem_ctrl: RV32 byte-addressed data memory controller with an IDLE -> ACCESS -> RESP handshake.
// Optional macro DMEM_MISALIGN_TRAP_EN: misaligned h/hu/sh/w accesses are rejected instead of aligned down.
module dmem_ctrl #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state;
  logic          q_we;
  logic [AW+1:0] q_addr;
  logic [31:0]   q_wdata;
  logic [2:0]    q_funct3;
  logic [31:0]   mem [DEPTH_WORDS];

  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic          f3_bad;
  logic          misal;
  logic          err_c;
  logic          wr_en;
  logic [3:0]    be;
  logic [31:0]   wd_lanes;
  logic [31:0]   rd_word;
  logic [31:0]   rd_shift;
  logic [31:0]   rdata_c;

  // Upper address bits wrap modulo the memory depth.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:AW+2];

  // Decode the latched request: legality, lane selection, store lanes and load extraction.
  always_comb begin
    idx    = q_addr[AW+1:2];
    f3_bad = (q_funct3 == 3'b011) || (q_funct3[2:1] == 2'b11) || (q_we && q_funct3[2]);
    case (q_funct3[1:0])
      2'b01:   lane = {q_addr[1], 1'b0};
      2'b10:   lane = 2'b00;
      default: lane = q_addr[1:0];
    endcase
`ifdef DMEM_MISALIGN_TRAP_EN
    misal = ((q_funct3[1:0] == 2'b01) && q_addr[0]) ||
            ((q_funct3[1:0] == 2'b10) && (q_addr[1:0] != 2'b00));
`else
    misal = 1'b0;
`endif
    err_c = f3_bad | misal;
    wr_en = q_we & ~err_c;

    case (q_funct3[1:0])
      2'b00: begin
        be       = 4'b0001 << lane;
        wd_lanes = {4{q_wdata[7:0]}};
      end
      2'b01: begin
        be       = 4'b0011 << lane;
        wd_lanes = {2{q_wdata[15:0]}};
      end
      default: begin
        be       = 4'b1111;
        wd_lanes = q_wdata;
      end
    endcase

    rd_word  = mem[idx];
    rd_shift = rd_word >> {lane, 3'b000};
    case (q_funct3)
      3'b000:  rdata_c = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  rdata_c = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  rdata_c = {24'd0, rd_shift[7:0]};
      3'b101:  rdata_c = {16'd0, rd_shift[15:0]};
      default: rdata_c = rd_shift;
    endcase
    if (err_c || q_we) rdata_c = '0;
  end

  // Request/response sequencing with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            q_we      <= req_we;
            q_addr    <= req_addr[AW+1:0];
            q_wdata   <= req_wdata;
            q_funct3  <= req_funct3;
            req_ready <= 1'b0;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          rsp_valid <= 1'b1;
          rsp_rdata <= rdata_c;
          rsp_err   <= err_c;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

  // Storage is never reset; a reset during ACCESS cancels the pending write.
  always_ff @(posedge clk) begin
    if (!rst && (state == ACCESS) && wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wd_lanes[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed scenarios plus random traffic against a byte-array model.
module tb_dmem_ctrl;

  localparam int unsigned DEPTH = 32;
  localparam int unsigned MEMB  = DEPTH * 4;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] mb [MEMB];

  dmem_ctrl #(.DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: RV32 load/store semantics on a flat byte array; updates memory for legal stores.
  function automatic void model(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                                input logic [2:0] f3, output logic [31:0] rd, output logic err);
    int size;
    bit sgn;
    int base;
    logic [31:0] v;
    err = 1'b0; rd = '0; size = 4; sgn = 1'b0;
    case (f3)
      3'd0: begin size = 1; sgn = 1'b1; end
      3'd1: begin size = 2; sgn = 1'b1; end
      3'd2: size = 4;
      3'd4: size = 1;
      3'd5: size = 2;
      default: err = 1'b1;
    endcase
    if (we && f3[2]) err = 1'b1;
    if (err) return;
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((addr % size) != 0) begin
      err = 1'b1;
      return;
    end
`endif
    base = int'(((addr % MEMB) / size) * size);
    if (we) begin
      for (int i = 0; i < size; i++) mb[base + i] = wd[8*i +: 8];
      return;
    end
    v = '0;
    for (int i = 0; i < size; i++) v[8*i +: 8] = mb[base + i];
    if (sgn && v[8*size - 1]) begin
      for (int b = 8*size; b < 32; b++) v[b] = 1'b1;
    end
    rd = v;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept_ready", 32'(req_ready), 32'd1);
  endtask

  // One full transaction; optionally stalls the response and offers another request meanwhile.
  task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [2:0] f3, input int hold, input bit offer,
                        output logic [31:0] got);
    logic [31:0] erd;
    logic        eerr;
    model(we, addr, wd, f3, erd, eerr);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_funct3 = f3;
    wait_ready();
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("access_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("access_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    chk("resp_valid", 32'(rsp_valid), 32'd1);
    chk("resp_rdata", rsp_rdata, erd);
    chk("resp_err", 32'(rsp_err), 32'(eerr));
    got = rsp_rdata;
    for (int k = 0; k < hold; k++) begin
      if (offer) begin
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h40; req_funct3 = 3'b010;
      end
      @(posedge clk); #1;
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rdata", rsp_rdata, erd);
      chk("hold_err", 32'(rsp_err), 32'(eerr));
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("done_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("done_req_ready", 32'(req_ready), 32'd1);
  endtask

  // Store word, then reset in ACCESS (write cancelled) or in RESP (write done, response dropped).
  task automatic do_abort(input logic [31:0] addr, input logic [31:0] wd, input bit in_resp);
    logic [31:0] erd;
    logic        eerr;
    if (in_resp) model(1'b1, addr, wd, 3'b010, erd, eerr);
    req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_wdata = wd; req_funct3 = 3'b010;
    wait_ready();
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (in_resp) begin
      @(posedge clk); #1;
      chk("abort_pre_valid", 32'(rsp_valid), 32'd1);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_rsp_rdata", rsp_rdata, 32'd0);
    chk("abort_rsp_err", 32'(rsp_err), 32'd0);
    @(posedge clk); #1;
    chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] got;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_funct3 = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int w = 0; w < int'(DEPTH); w++) do_req(1'b1, 32'(w * 4), $urandom, 3'b010, 0, 1'b0, got);

    do_req(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 0, 1'b0, got);
    chk("sw_rdata_zero", got, 32'd0);
    do_req(1'b0, 32'h10, 32'h0, 3'b010, 0, 1'b0, got);
    chk("lw_deadbeef", got, 32'hDEADBEEF);

    do_req(1'b1, 32'h10, 32'h0, 3'b010, 0, 1'b0, got);
    do_req(1'b1, 32'h13, 32'h80, 3'b000, 0, 1'b0, got);
    do_req(1'b0, 32'h13, 32'h0, 3'b000, 0, 1'b0, got);
    chk("lb_sext", got, 32'hFFFFFF80);
    do_req(1'b0, 32'h13, 32'h0, 3'b100, 0, 1'b0, got);
    chk("lbu_zext", got, 32'h00000080);
    do_req(1'b0, 32'h10, 32'h0, 3'b010, 0, 1'b0, got);
    chk("lw_after_sb", got, 32'h80000000);

    do_req(1'b1, 32'h20, 32'h0, 3'b010, 0, 1'b0, got);
    do_req(1'b1, 32'h22, 32'h1234, 3'b001, 0, 1'b0, got);
    do_req(1'b0, 32'h20, 32'h0, 3'b010, 0, 1'b0, got);
    chk("lw_after_sh", got, 32'h12340000);
    do_req(1'b0, 32'h22, 32'h0, 3'b101, 0, 1'b0, got);
    chk("lhu", got, 32'h00001234);

    do_req(1'b0, 32'h11, 32'h0, 3'b010, 0, 1'b0, got);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("lw_misaligned", got, 32'h0);
`else
    chk("lw_misaligned", got, 32'h80000000);
`endif

    do_req(1'b1, 32'h24, 32'hCAFE, 3'b101, 0, 1'b0, got);
    do_req(1'b0, 32'h24, 32'h0, 3'b011, 0, 1'b0, got);
    do_req(1'b0, 32'h24, 32'h0, 3'b111, 0, 1'b0, got);

    do_req(1'b1, 32'h40, 32'h13579BDF, 3'b010, 5, 1'b1, got);
    do_req(1'b0, 32'h40, 32'h0, 3'b010, 0, 1'b0, got);
    chk("lw_after_stall", got, 32'h13579BDF);

    do_abort(32'h40, 32'h5555AAAA, 1'b0);
    do_req(1'b0, 32'h40, 32'h0, 3'b010, 0, 1'b0, got);
    chk("lw_after_abort", got, 32'h13579BDF);
    do_abort(32'h44, 32'h0F0F1234, 1'b1);
    do_req(1'b0, 32'h44, 32'h0, 3'b010, 0, 1'b0, got);
    chk("lw_after_resp_abort", got, 32'h0F0F1234);

    do_req(1'b1, 32'h30 + 32'(MEMB) * 3, 32'hA5A5C3C3, 3'b010, 0, 1'b0, got);
    do_req(1'b0, 32'h30, 32'h0, 3'b010, 0, 1'b0, got);
    chk("lw_wrap", got, 32'hA5A5C3C3);

    for (int t = 0; t < 200; t++) begin
      do_req(1'($urandom_range(0, 1)), $urandom, $urandom, 3'($urandom_range(0, 7)),
             int'($urandom_range(0, 2)), 1'b0, got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
